// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, per-bit edge counter and mid-bit sampler.
// UART_RX_MAJORITY_EN selects a 3-sample majority vote per bit.
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic active,
  output logic rxs,
  output logic tick,
  output logic wrap,
  output logic bit_val
);

  localparam int CW = $clog2(PRESCALE);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rxs  = sync_q[1];
  assign wrap = (cnt_q == CW'(PRESCALE - 1));

  // The IDLE cycle that sees the start edge counts as edge 0.
  always_comb begin
    cnt_d = cnt_q;
    if (active) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = rxs ? '0 : CW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (cnt_q == CW'(PRESCALE / 2 - 2)) maj_d[0] = rxs;
    if (cnt_q == CW'(PRESCALE / 2 - 1)) maj_d[1] = rxs;
  end

  assign tick    = (cnt_q == CW'(PRESCALE / 2));
  assign bit_val = (maj_q[0] & maj_q[1]) |
                   (maj_q[0] & rxs) |
                   (maj_q[1] & rxs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) maj_q <= 2'b11;
    else      maj_q <= maj_d;
  end
`else
  assign tick    = (cnt_q == CW'(PRESCALE / 2 - 1));
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8N/8P data, stop; one-cycle result strobes.
// Build option UART_RX_MAJORITY_EN lives in uart_rx_sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  perr_q, perr_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic rxs, tick, wrap, bit_val;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk    (clk),
    .rst    (rst),
    .rx_in  (rx_in),
    .active (state_q != IDLE),
    .rxs    (rxs),
    .tick   (tick),
    .wrap   (wrap),
    .bit_val(bit_val)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    pen_d     = pen_q;
    ptyp_d    = ptyp_q;
    perr_d    = perr_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          pen_d     = par_en;
          ptyp_d    = par_typ;
          perr_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tick && bit_val) state_d = IDLE;
        else if (wrap)       state_d = DATA;
      end
      DATA: begin
        if (tick) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (wrap) begin
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick && (bit_val != (^shift_q ^ (ptyp_q == PAR_ODD))))
          perr_d = 1'b1;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop so a slightly early next start is caught.
        if (tick) begin
          state_d = IDLE;
          dv_d    = bit_val & ~perr_q;
          pe_d    = perr_q;
          se_d    = ~bit_val;
          if (bit_val && !perr_q) p_data_d = shift_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      pen_q     <= 1'b0;
      ptyp_q    <= 1'b0;
      perr_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      perr_q    <= perr_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = (state_q != IDLE);

endmodule
